// File: rtl/logsys_io_pkg.sv
// Shared LOGSYS I/O definitions: tick rate, width helper and
// the per-channel debounce state encoding {stable, dcnt != 0}.
package logsys_io_pkg;

  localparam int TICK_HZ = 1000;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/logsys_btn_debounce_if.sv
// Button conditioner bundle: raw pads in, clean levels and
// event pulses out, plus per-channel debounce state.
interface logsys_btn_debounce_if
  import logsys_io_pkg::*;
#(
  parameter int N = 3
);

  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_out;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;
  logic         tick;
  btn_state_e   state [N];

  modport slave (
    input  btn_raw,
    output btn_out,
    output press_pulse,
    output release_pulse,
    output long_press,
    output tick,
    output state
  );

  modport master (
    output btn_raw,
    input  btn_out,
    input  press_pulse,
    input  release_pulse,
    input  long_press,
    input  tick,
    input  state
  );

endinterface

// File: rtl/logsys_btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-driven debounce
// and saturating hold counter (LOGSYS_BTN_AUTOREPEAT_EN adds repeats).
module logsys_btn_debounce_ch
  import logsys_io_pkg::*;
#(
  parameter int C_STABLE_TICKS = 8,
`ifdef LOGSYS_BTN_AUTOREPEAT_EN
  parameter int C_REPEAT_TICKS = 200,
`endif
  parameter int C_LONG_TICKS   = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       btn_raw_i,
  output logic       btn_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output btn_state_e state_o
);

  localparam int DW = clog2(C_STABLE_TICKS + 1);
  localparam int HW = clog2(C_LONG_TICKS + 1);
  localparam logic [DW-1:0] DMAX = DW'(C_STABLE_TICKS - 1);
  localparam logic [HW-1:0] HLONG = HW'(C_LONG_TICKS);
`ifdef LOGSYS_BTN_AUTOREPEAT_EN
  localparam logic [HW-1:0] HREST =
    HW'(C_LONG_TICKS - C_REPEAT_TICKS);
`endif

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          sync;

  assign sync = sync_q[1];

  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    hcnt_d   = hcnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    if (tick_i) begin
      if (sync == stable_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DMAX) begin
        stable_d = sync;
        dcnt_d   = '0;
        press_d  = sync;
        rel_d    = ~sync;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
      // an accepted edge in either direction restarts the hold
      if (!stable_q || press_d || rel_d) begin
        hcnt_d = '0;
      end else if (hcnt_q < HLONG) begin
        hcnt_d = hcnt_q + HW'(1);
        if (hcnt_d == HLONG) begin
          long_d = 1'b1;
`ifdef LOGSYS_BTN_AUTOREPEAT_EN
          hcnt_d = HREST;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
      hcnt_q   <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_raw_i};
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      hcnt_q   <= hcnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
    end
  end

  assign btn_o     = stable_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
  assign state_o   = btn_state_e'({stable_q, dcnt_q != '0});

endmodule

// File: rtl/logsys_btn_debounce.sv
// LOGSYS push-button conditioner: 1 kHz tick plus C_NUM_BTN
// debounce channels. Optional macro: LOGSYS_BTN_AUTOREPEAT_EN.
module logsys_btn_debounce
  import logsys_io_pkg::*;
#(
  parameter int C_NUM_BTN            = 3,
  parameter int C_S_AXI_ACLK_FREQ_HZ = 100000000,
  parameter int C_STABLE_TICKS       = 8,
  parameter int C_LONG_TICKS         = 1000,
  parameter int C_REPEAT_TICKS       = 200
) (
  input  logic Bus2IP_Clk,
  input  logic Bus2IP_Resetn,
  logsys_btn_debounce_if.slave bus
);

  localparam int TICK_DIV = C_S_AXI_ACLK_FREQ_HZ / TICK_HZ;
  localparam int TW = clog2(TICK_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(TICK_DIV - 1);

  if (C_STABLE_TICKS < 1 ||
      C_LONG_TICKS <= C_STABLE_TICKS ||
      C_REPEAT_TICKS < 1 ||
      C_REPEAT_TICKS > C_LONG_TICKS) begin : g_bad_cfg
    $error("logsys_btn_debounce: bad tick parameters");
  end

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick;

  assign tick   = (tcnt_q == '0);
  assign tcnt_d = tick ? RELOAD : tcnt_q - TW'(1);

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) tcnt_q <= RELOAD;
    else                tcnt_q <= tcnt_d;
  end

  logic [C_NUM_BTN-1:0] out_w, press_w, rel_w, long_w;
  btn_state_e           st_w [C_NUM_BTN];

  for (genvar g = 0; g < C_NUM_BTN; g++) begin : g_ch
    logsys_btn_debounce_ch #(
      .C_STABLE_TICKS (C_STABLE_TICKS),
`ifdef LOGSYS_BTN_AUTOREPEAT_EN
      .C_REPEAT_TICKS (C_REPEAT_TICKS),
`endif
      .C_LONG_TICKS   (C_LONG_TICKS)
    ) u_ch (
      .clk_i     (Bus2IP_Clk),
      .rst_ni    (Bus2IP_Resetn),
      .tick_i    (tick),
      .btn_raw_i (bus.btn_raw[g]),
      .btn_o     (out_w[g]),
      .press_o   (press_w[g]),
      .release_o (rel_w[g]),
      .long_o    (long_w[g]),
      .state_o   (st_w[g])
    );
  end

  assign bus.tick          = tick;
  assign bus.btn_out       = out_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = rel_w;
  assign bus.long_press    = long_w;
  assign bus.state         = st_w;

endmodule

// File: tb/tb_logsys_btn_debounce.sv
// Directed bench for logsys_btn_debounce: TICK_DIV=100,
// 4 stable ticks, 20 long ticks, 5 repeat ticks.
module tb_logsys_btn_debounce;
  import logsys_io_pkg::*;

  localparam int N    = 3;
  localparam int FREQ = 100000;
  localparam int TD   = 100;
  localparam int ST   = 4;
  localparam int LT   = 20;
  localparam int RT   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logsys_btn_debounce_if #(.N(N)) bus ();

  logsys_btn_debounce #(
    .C_NUM_BTN            (N),
    .C_S_AXI_ACLK_FREQ_HZ (FREQ),
    .C_STABLE_TICKS       (ST),
    .C_LONG_TICKS         (LT),
    .C_REPEAT_TICKS       (RT)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int pcnt [N] = '{default: 0};
  int rcnt [N] = '{default: 0};
  int lcnt [N] = '{default: 0};
  int last_long [N] = '{default: 0};

  always @(negedge clk) begin
    if (bus.tick === 1'b1) tick_cnt++;
    for (int i = 0; i < N; i++) begin
      if (bus.press_pulse[i] === 1'b1) pcnt[i]++;
      if (bus.release_pulse[i] === 1'b1) rcnt[i]++;
      if (bus.long_press[i] === 1'b1) begin
        lcnt[i]++;
        last_long[i] = tick_cnt;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_out(input int ch, input logic val,
                          input int limit, output int n);
    n = 0;
    while (bus.btn_out[ch] !== val && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic wait_tick_cnt(input int target);
    int n;
    n = 0;
    while (tick_cnt < target && n < 6000) begin
      step();
      n++;
    end
    chk("tick_wait_timeout", 32'(tick_cnt >= target), 1);
  endtask

  initial begin
    int cyc, n, ta, tk;
    int p0, p1, r0, l0;

    bus.btn_raw = 3'b111;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_btn_out", 32'(bus.btn_out), 0);
    chk("rst_press", 32'(bus.press_pulse), 0);
    chk("rst_release", 32'(bus.release_pulse), 0);
    chk("rst_long", 32'(bus.long_press), 0);
    chk("rst_tick", 32'(bus.tick), 0);

    // cycle 1 is the cycle in which reset is released
    rst_n = 1'b1;
    cyc = 1;
    while (bus.tick !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
    chk("first_tick_cycle", 32'(cyc), TD);
    while (bus.btn_out === 3'b000 && cyc < 600) begin
      step();
      cyc++;
    end
    chk("accept_cycle", 32'(cyc), 4 * TD + 1);
    chk("accept_btn_out", 32'(bus.btn_out), 3'b111);
    chk("accept_press", 32'(bus.press_pulse), 3'b111);
    step();
    chk("press_one_cycle", 32'(bus.press_pulse), 0);
    chk("press_cnt0", 32'(pcnt[0]), 1);
    chk("press_cnt2", 32'(pcnt[2]), 1);

    bus.btn_raw = 3'b000;
    wait_out(0, 1'b0, 500, n);
    chk("rel_all_btn_out", 32'(bus.btn_out), 0);
    chk("rel_all_pulse", 32'(bus.release_pulse), 3'b111);
    chk("rel_all_cnt1", 32'(rcnt[1]), 1);
    chk("rel_all_no_long", 32'(lcnt[0] + lcnt[1] + lcnt[2]), 0);

    // glitch on channel 0: 250 clocks high
    p0 = pcnt[0];
    r0 = rcnt[0];
    bus.btn_raw[0] = 1'b1;
    repeat (250) step();
    chk("glitch_state_wait", 32'(bus.state[0]), 32'(PRESS_WAIT));
    bus.btn_raw[0] = 1'b0;
    repeat (600) step();
    chk("glitch_btn_out", 32'(bus.btn_out[0]), 0);
    chk("glitch_no_press", 32'(pcnt[0] - p0), 0);
    chk("glitch_no_release", 32'(rcnt[0] - r0), 0);
    chk("glitch_state_rel", 32'(bus.state[0]), 32'(RELEASED));

    // clean press/release on channel 1
    p1 = pcnt[1];
    r0 = rcnt[1];
    bus.btn_raw[1] = 1'b1;
    wait_out(1, 1'b1, 500, n);
    chk("clean_rise", 32'(bus.btn_out[1]), 1);
    chk("clean_rise_lat_ok", 32'(n >= 300 && n <= 402), 1);
    chk("clean_state", 32'(bus.state[1]), 32'(PRESSED));
    repeat (3000 - n) step();
    bus.btn_raw[1] = 1'b0;
    wait_out(1, 1'b0, 500, n);
    chk("clean_fall", 32'(bus.btn_out[1]), 0);
    chk("clean_fall_lat_ok", 32'(n >= 300 && n <= 402), 1);
    chk("clean_press_cnt", 32'(pcnt[1] - p1), 1);
    chk("clean_release_cnt", 32'(rcnt[1] - r0), 1);

    // long press on channel 2
    l0 = lcnt[2];
    bus.btn_raw[2] = 1'b1;
    wait_out(2, 1'b1, 500, n);
    chk("long_accept", 32'(bus.btn_out[2]), 1);
    ta = tick_cnt;
    wait_tick_cnt(ta + LT - 1);
    repeat (2) step();
    chk("long_not_early", 32'(lcnt[2] - l0), 0);
    wait_tick_cnt(ta + LT);
    repeat (2) step();
    chk("long_first_cnt", 32'(lcnt[2] - l0), 1);
    chk("long_first_tick", 32'(last_long[2] - ta), LT);
`ifdef LOGSYS_BTN_AUTOREPEAT_EN
    wait_tick_cnt(ta + LT + 4 * RT);
    repeat (2) step();
    chk("repeat_cnt", 32'(lcnt[2] - l0), 5);
    chk("repeat_last_tick", 32'(last_long[2] - ta), LT + 4 * RT);
`else
    wait_tick_cnt(ta + 30);
    repeat (2) step();
    chk("long_single_cnt", 32'(lcnt[2] - l0), 1);
`endif
    bus.btn_raw[2] = 1'b0;
    wait_out(2, 1'b0, 500, n);
    chk("long_release", 32'(bus.btn_out[2]), 0);
    l0 = lcnt[2];
    repeat (1000) step();
    chk("long_none_after_rel", 32'(lcnt[2] - l0), 0);

    // reset in the middle of a channel-0 debounce
    bus.btn_raw = 3'b010;
    wait_out(1, 1'b1, 500, n);
    chk("mid_ch1_held", 32'(bus.btn_out), 3'b010);
    bus.btn_raw[0] = 1'b1;
    n = 0;
    while (bus.state[0] !== PRESS_WAIT && n < 500) begin
      step();
      n++;
    end
    tk = tick_cnt;
    wait_tick_cnt(tk + 1);
    step();
    chk("mid_state_wait", 32'(bus.state[0]), 32'(PRESS_WAIT));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_btn_out", 32'(bus.btn_out), 0);
    chk("mid_rst_state", 32'(bus.state[0]), 32'(RELEASED));
    repeat (3) step();
    p0 = pcnt[0];
    p1 = pcnt[1];
    rst_n = 1'b1;
    cyc = 1;
    while (bus.btn_out === 3'b000 && cyc < 600) begin
      step();
      cyc++;
    end
    chk("reacc_cycle", 32'(cyc), 4 * TD + 1);
    chk("reacc_btn_out", 32'(bus.btn_out), 3'b011);
    chk("reacc_press", 32'(bus.press_pulse), 3'b011);
    step();
    chk("reacc_cnt0", 32'(pcnt[0] - p0), 1);
    chk("reacc_cnt1", 32'(pcnt[1] - p1), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
